// File: rtl/blood_sprite_renderer_pkg.sv
// blood_pkg: shared constants, state type and width helper for the
// blood-splatter sprite renderer (blood_sprite_renderer, blood_anim_ctrl,
// blood_sprite_renderer_if).
package blood_pkg;

    localparam int SPRITE_DIM = 64;
    localparam int SPRITE_AW  = 6;
    localparam int COLOR_W    = 12;
    localparam int SCREEN_W   = 10;

    localparam logic [COLOR_W-1:0] TRANSPARENT_DEF = 12'h000;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } blood_state_e;

    // Counter width for n states; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/blood_sprite_renderer_if.sv
// blood_sprite_renderer_if: scan, sprite-ROM and pixel-output bundle.
//   master: video timing / ROM side (drives pixel_x, pixel_y, video_on, rom_color)
//   slave : renderer (drives rom_row, rom_col, frame_idx, sprite_on, rgb)
interface blood_sprite_renderer_if #(parameter int NUM_FRAMES = 8);
    import blood_pkg::*;

    localparam int FIW = blood_pkg::idx_w(NUM_FRAMES);

    logic [SCREEN_W-1:0]  pixel_x;
    logic [SCREEN_W-1:0]  pixel_y;
    logic                 video_on;
    logic [SPRITE_AW-1:0] rom_row;
    logic [SPRITE_AW-1:0] rom_col;
    logic [FIW-1:0]       frame_idx;
    logic [COLOR_W-1:0]   rom_color;
    logic                 sprite_on;
    logic [COLOR_W-1:0]   rgb;

    modport master (
        output pixel_x, pixel_y, video_on, rom_color,
        input  rom_row, rom_col, frame_idx, sprite_on, rgb
    );

    modport slave (
        input  pixel_x, pixel_y, video_on, rom_color,
        output rom_row, rom_col, frame_idx, sprite_on, rgb
    );

endinterface

// File: rtl/blood_sprite_renderer_anim_ctrl.sv
// blood_anim_ctrl: one-shot animation sequencer and trigger latch.
// Ports: clk_i, reset_i (sync, active-high), trigger_i, frame_tick_i,
//        pos_x_i/pos_y_i (latched on trigger), busy_o, frame_idx_o,
//        pos_x_o/pos_y_o (latched position).
// Optional BLOOD_MIRROR_EN: mirror_i latched alongside the position -> mirror_o.
//
// state | meaning
// IDLE  | no animation, frame_idx held at 0
// PLAY  | animation running, frame_idx advances every HOLD_FRAMES frame_ticks
module blood_anim_ctrl
    import blood_pkg::*;
#(
    parameter int NUM_FRAMES  = 8,
    parameter int HOLD_FRAMES = 4,
    localparam int FIW = idx_w(NUM_FRAMES)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                trigger_i,
    input  logic                frame_tick_i,
    input  logic [SCREEN_W-1:0] pos_x_i,
    input  logic [SCREEN_W-1:0] pos_y_i,
`ifdef BLOOD_MIRROR_EN
    input  logic                mirror_i,
    output logic                mirror_o,
`endif
    output logic                busy_o,
    output logic [FIW-1:0]      frame_idx_o,
    output logic [SCREEN_W-1:0] pos_x_o,
    output logic [SCREEN_W-1:0] pos_y_o
);

    localparam int HCW = idx_w(HOLD_FRAMES);
    localparam logic [HCW-1:0] HOLD_LAST  = HCW'(HOLD_FRAMES - 1);
    localparam logic [FIW-1:0] FRAME_LAST = FIW'(NUM_FRAMES - 1);

    blood_state_e        state_q, state_d;
    logic [FIW-1:0]      frame_idx_q, frame_idx_d;
    logic [HCW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [SCREEN_W-1:0] pos_x_q, pos_x_d;
    logic [SCREEN_W-1:0] pos_y_q, pos_y_d;
`ifdef BLOOD_MIRROR_EN
    logic                mirror_q, mirror_d;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            frame_idx_q <= '0;
            hold_cnt_q  <= '0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
`ifdef BLOOD_MIRROR_EN
            mirror_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            frame_idx_q <= frame_idx_d;
            hold_cnt_q  <= hold_cnt_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
`ifdef BLOOD_MIRROR_EN
            mirror_q    <= mirror_d;
`endif
        end
    end

    // Trigger has priority over frame_tick, so a retrigger always restarts
    // cleanly at frame 0 even on a frame-advancing tick.
    always_comb begin
        state_d     = state_q;
        frame_idx_d = frame_idx_q;
        hold_cnt_d  = hold_cnt_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
`ifdef BLOOD_MIRROR_EN
        mirror_d    = mirror_q;
`endif
        if (trigger_i) begin
            state_d     = PLAY;
            frame_idx_d = '0;
            hold_cnt_d  = '0;
            pos_x_d     = pos_x_i;
            pos_y_d     = pos_y_i;
`ifdef BLOOD_MIRROR_EN
            mirror_d    = mirror_i;
`endif
        end else if (state_q == PLAY && frame_tick_i) begin
            if (hold_cnt_q < HOLD_LAST) begin
                hold_cnt_d = hold_cnt_q + HCW'(1);
            end else begin
                hold_cnt_d = '0;
                if (frame_idx_q < FRAME_LAST) begin
                    frame_idx_d = frame_idx_q + FIW'(1);
                end else begin
                    state_d     = IDLE;
                    frame_idx_d = '0;
                end
            end
        end
    end

    assign busy_o      = (state_q == PLAY);
    assign frame_idx_o = frame_idx_q;
    assign pos_x_o     = pos_x_q;
    assign pos_y_o     = pos_y_q;
`ifdef BLOOD_MIRROR_EN
    assign mirror_o    = mirror_q;
`endif

endmodule

// File: rtl/blood_sprite_renderer.sv
// blood_sprite_renderer: maps the VGA scan position onto the 64x64 blood
// sprite ROMs, absorbs the one-cycle ROM latency and emits a registered,
// transparency-keyed pixel two clocks after the scan position.
// Ports: clk_i, reset_i (sync, active-high), trigger_i, pos_x_i, pos_y_i,
//        frame_tick_i, busy_o, vid (blood_sprite_renderer_if.slave: scan
//        position, ROM address/data, frame_idx, sprite_on, rgb).
// Optional BLOOD_MIRROR_EN: adds mirror_i; a latched 1 flips rom_col horizontally.
module blood_sprite_renderer
    import blood_pkg::*;
#(
    parameter int                 NUM_FRAMES  = 8,
    parameter int                 HOLD_FRAMES = 4,
    parameter logic [COLOR_W-1:0] TRANSPARENT = TRANSPARENT_DEF
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                trigger_i,
    input  logic [SCREEN_W-1:0] pos_x_i,
    input  logic [SCREEN_W-1:0] pos_y_i,
    input  logic                frame_tick_i,
`ifdef BLOOD_MIRROR_EN
    input  logic                mirror_i,
`endif
    output logic                busy_o,
    blood_sprite_renderer_if.slave vid
);

    localparam int FIW = idx_w(NUM_FRAMES);

    logic [FIW-1:0]      frame_idx;
    logic [SCREEN_W-1:0] pos_x_l, pos_y_l;
    logic                busy;
`ifdef BLOOD_MIRROR_EN
    logic                mirror_l;
`endif

    blood_anim_ctrl #(
        .NUM_FRAMES  (NUM_FRAMES),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_anim_ctrl (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .trigger_i    (trigger_i),
        .frame_tick_i (frame_tick_i),
        .pos_x_i      (pos_x_i),
        .pos_y_i      (pos_y_i),
`ifdef BLOOD_MIRROR_EN
        .mirror_i     (mirror_i),
        .mirror_o     (mirror_l),
`endif
        .busy_o       (busy),
        .frame_idx_o  (frame_idx),
        .pos_x_o      (pos_x_l),
        .pos_y_o      (pos_y_l)
    );

    // Extra top bit turns a negative offset into a large value, so one
    // "upper bits zero" test covers both the left/top and right/bottom edges.
    logic [SCREEN_W:0] dx, dy;
    logic              hit1_d, hit1_q;
    logic              sprite_on_q;
    logic [COLOR_W-1:0] rgb_q;

    assign dx = {1'b0, vid.pixel_x} - {1'b0, pos_x_l};
    assign dy = {1'b0, vid.pixel_y} - {1'b0, pos_y_l};

    assign hit1_d = busy & vid.video_on
                  & (dx[SCREEN_W:SPRITE_AW] == '0)
                  & (dy[SCREEN_W:SPRITE_AW] == '0);

    assign vid.rom_row = dy[SPRITE_AW-1:0];
`ifdef BLOOD_MIRROR_EN
    assign vid.rom_col = mirror_l ? (SPRITE_AW'(SPRITE_DIM - 1) - dx[SPRITE_AW-1:0])
                                  : dx[SPRITE_AW-1:0];
`else
    assign vid.rom_col = dx[SPRITE_AW-1:0];
`endif

    // rom_color lines up with hit1_q: both reflect the previous cycle's address.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hit1_q      <= 1'b0;
            sprite_on_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            hit1_q      <= hit1_d;
            sprite_on_q <= hit1_q & (vid.rom_color != TRANSPARENT);
            rgb_q       <= hit1_q ? vid.rom_color : '0;
        end
    end

    assign vid.sprite_on = sprite_on_q;
    assign vid.rgb       = rgb_q;
    assign vid.frame_idx = frame_idx;
    assign busy_o        = busy;

endmodule

// File: tb/tb_blood_sprite_renderer.sv
module tb_blood_sprite_renderer;

    localparam int NF   = 8;
    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       trigger = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] pos_x = '0;
    logic [9:0] pos_y = '0;
    logic       mirror = 1'b0;
    logic       busy;

    int n_total = 0;
    int n_pass  = 0;

    blood_sprite_renderer_if #(.NUM_FRAMES(NF)) vif();

    blood_sprite_renderer #(
        .NUM_FRAMES  (NF),
        .HOLD_FRAMES (HOLD),
        .TRANSPARENT (12'h000)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .trigger_i    (trigger),
        .pos_x_i      (pos_x),
        .pos_y_i      (pos_y),
        .frame_tick_i (frame_tick),
`ifdef BLOOD_MIRROR_EN
        .mirror_i     (mirror),
`endif
        .busy_o       (busy),
        .vid          (vif.slave)
    );

    always #5 clk = ~clk;

    // ROM model: registered address, data word is {row, col}.
    always @(posedge clk) vif.rom_color <= {vif.rom_row, vif.rom_col};

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    bit m_busy   = 0;
    int m_px     = 0;
    int m_py     = 0;
    bit m_mirror = 0;
    int m_ticks  = 0;

    function automatic logic [12:0] ref_pix(input int x, input int y, input bit v);
        int ox, oy, col;
        logic [11:0] data;
        ox = x - m_px;
        oy = y - m_py;
        if (!m_busy || !v || ox < 0 || ox > 63 || oy < 0 || oy > 63) return 13'h0;
        col  = m_mirror ? 63 - ox : ox;
        data = {oy[5:0], col[5:0]};
        return {(data != 12'h000), data};
    endfunction

    function automatic int ref_idx();
        return m_busy ? (m_ticks / HOLD) : 0;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    bit          va, vb;
    logic [12:0] ea, eb;

    task automatic pix_start();
        va = 0;
        vb = 0;
    endtask

    // Drives one scan position per clock; returns the expectation that
    // matches the outputs visible now (inputs driven two calls ago).
    task automatic pix(input int x, input int y, input bit v,
                       output bit chk, output logic [12:0] e);
        @(posedge clk); #1;
        chk = vb;
        e   = eb;
        vb  = va;
        eb  = ea;
        vif.pixel_x  = x[9:0];
        vif.pixel_y  = y[9:0];
        vif.video_on = v;
        ea = ref_pix(x, y, v);
        va = 1;
    endtask

    task automatic do_trigger(input int x, input int y, input bit mir,
                              output bit b_before, output bit b_after);
        @(posedge clk); #1;
        trigger = 1'b1;
        pos_x   = x[9:0];
        pos_y   = y[9:0];
        mirror  = mir;
        #3 b_before = busy;
        @(posedge clk); #1;
        trigger = 1'b0;
        b_after = busy;
        m_busy  = 1;
        m_px    = x;
        m_py    = y;
        m_ticks = 0;
`ifdef BLOOD_MIRROR_EN
        m_mirror = mir;
`else
        m_mirror = 0;
`endif
    endtask

    task automatic do_tick();
        @(posedge clk); #1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        if (m_busy) begin
            m_ticks++;
            if (m_ticks == NF * HOLD) begin
                m_busy  = 0;
                m_ticks = 0;
            end
        end
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        vif.pixel_x = 10'd77; vif.pixel_y = 10'd333; vif.video_on = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (vif.sprite_on !== 1'b0) $display("FAIL reset_sprite_on: got %b expected 0", vif.sprite_on); else n_pass++;
        n_total++; if (vif.rgb !== 12'h000) $display("FAIL reset_rgb: got %h expected 000", vif.rgb); else n_pass++;
        n_total++; if (vif.frame_idx !== 3'd0) $display("FAIL reset_frame_idx: got %0d expected 0", vif.frame_idx); else n_pass++;
        n_total++; if (vif.rom_row !== 6'(333 % 64)) $display("FAIL reset_rom_row: got %0d expected %0d", vif.rom_row, 333 % 64); else n_pass++;
        n_total++; if (vif.rom_col !== 6'(77 % 64)) $display("FAIL reset_rom_col: got %0d expected %0d", vif.rom_col, 77 % 64); else n_pass++;
    endtask

    task automatic test_idle_scan();
        bit chk; logic [12:0] e;
        pix_start();
        for (int i = 0; i < 2000; i++) begin
            pix($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, chk, e);
            if (chk) begin
                n_total++;
                if ({vif.sprite_on, vif.rgb} !== e || busy !== 1'b0)
                    $display("FAIL idle_scan: got on=%b rgb=%h busy=%b expected on=%b rgb=%h busy=0",
                             vif.sprite_on, vif.rgb, busy, e[12], e[11:0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_basic_render();
        bit chk, bb, ba; logic [12:0] e;
        do_trigger(100, 50, 1'b0, bb, ba);
        n_total++; if (bb !== 1'b0) $display("FAIL trig_busy_same_cycle: got %b expected 0", bb); else n_pass++;
        n_total++; if (ba !== 1'b1) $display("FAIL trig_busy_next_clock: got %b expected 1", ba); else n_pass++;
        pix_start();
        for (int y = 48; y <= 115; y++)
            for (int x = 98; x <= 165; x++) begin
                pix(x, y, 1'b1, chk, e);
                if (chk) begin
                    n_total++;
                    if ({vif.sprite_on, vif.rgb} !== e)
                        $display("FAIL basic_render: got on=%b rgb=%h expected on=%b rgb=%h",
                                 vif.sprite_on, vif.rgb, e[12], e[11:0]);
                    else n_pass++;
                end
            end
        pix(110, 60, 1'b1, chk, e);
        pix(99, 50, 1'b1, chk, e);
        pix(164, 50, 1'b1, chk, e);
        n_total++; if ({vif.sprite_on, vif.rgb} !== {1'b1, 12'h28A}) $display("FAIL pixel_110_60: got on=%b rgb=%h expected on=1 rgb=28a", vif.sprite_on, vif.rgb); else n_pass++;
        pix(0, 0, 1'b0, chk, e);
        n_total++; if (vif.sprite_on !== 1'b0) $display("FAIL pixel_99_50: got %b expected 0", vif.sprite_on); else n_pass++;
        pix(0, 0, 1'b0, chk, e);
        n_total++; if (vif.sprite_on !== 1'b0) $display("FAIL pixel_164_50: got %b expected 0", vif.sprite_on); else n_pass++;
    endtask

    task automatic test_edge_clip();
        bit chk, bb, ba; logic [12:0] e;
        do_trigger(620, 470, 1'b0, bb, ba);
        pix_start();
        for (int y = 460; y <= 479; y++)
            for (int xi = 0; xi < 84; xi++) begin
                pix((xi < 40) ? 600 + xi : xi - 40, y, 1'b1, chk, e);
                if (chk) begin
                    n_total++;
                    if ({vif.sprite_on, vif.rgb} !== e)
                        $display("FAIL edge_clip: got on=%b rgb=%h expected on=%b rgb=%h",
                                 vif.sprite_on, vif.rgb, e[12], e[11:0]);
                    else n_pass++;
                end
            end
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 44; x++) begin
                pix(x, y, 1'b1, chk, e);
                if (chk) begin
                    n_total++;
                    if (vif.sprite_on !== 1'b0) $display("FAIL edge_wrap: got %b expected 0", vif.sprite_on); else n_pass++;
                end
            end
    endtask

    task automatic test_random_render();
        bit chk, bb, ba; logic [12:0] e;
        int px, py, x, y;
        for (int k = 0; k < 4; k++) begin
            px = $urandom_range(0, 639);
            py = $urandom_range(0, 479);
            do_trigger(px, py, 1'b0, bb, ba);
            pix_start();
            for (int i = 0; i < 600; i++) begin
                x = px - 8 + $urandom_range(0, 79);
                y = py - 8 + $urandom_range(0, 79);
                if (x < 0) x = 0;
                if (x > 639) x = 639;
                if (y < 0) y = 0;
                if (y > 479) y = 479;
                pix(x, y, ($urandom_range(0, 9) != 0), chk, e);
                if (chk) begin
                    n_total++;
                    if ({vif.sprite_on, vif.rgb} !== e)
                        $display("FAIL random_render: got on=%b rgb=%h expected on=%b rgb=%h",
                                 vif.sprite_on, vif.rgb, e[12], e[11:0]);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_animation();
        bit bb, ba;
        do_trigger(10, 10, 1'b0, bb, ba);
        for (int t = 0; t <= NF * HOLD; t++) begin
            n_total++;
            if (vif.frame_idx !== 3'(ref_idx()) || busy !== m_busy)
                $display("FAIL animation_tick%0d: got idx=%0d busy=%b expected idx=%0d busy=%b",
                         t, vif.frame_idx, busy, ref_idx(), m_busy);
            else n_pass++;
            if (t < NF * HOLD) do_tick();
        end
        n_total++; if (busy !== 1'b0 || vif.frame_idx !== 3'd0) $display("FAIL animation_end: got busy=%b idx=%0d expected busy=0 idx=0", busy, vif.frame_idx); else n_pass++;
    endtask

    task automatic test_retrigger();
        bit chk, bb, ba; logic [12:0] e;
        do_trigger(100, 100, 1'b0, bb, ba);
        repeat (20) do_tick();
        n_total++; if (vif.frame_idx !== 3'd5) $display("FAIL retrig_frame5: got %0d expected 5", vif.frame_idx); else n_pass++;
        do_trigger(300, 200, 1'b0, bb, ba);
        n_total++; if (vif.frame_idx !== 3'd0 || busy !== 1'b1) $display("FAIL retrig_restart: got idx=%0d busy=%b expected idx=0 busy=1", vif.frame_idx, busy); else n_pass++;
        pix_start();
        for (int i = 0; i < 500; i++) begin
            pix(280 + $urandom_range(0, 99), 180 + $urandom_range(0, 99), 1'b1, chk, e);
            if (chk) begin
                n_total++;
                if ({vif.sprite_on, vif.rgb} !== e)
                    $display("FAIL retrig_position: got on=%b rgb=%h expected on=%b rgb=%h",
                             vif.sprite_on, vif.rgb, e[12], e[11:0]);
                else n_pass++;
            end
        end
        repeat (7) do_tick();
        n_total++; if (vif.frame_idx !== 3'd1) $display("FAIL retrig_pre_coincident: got %0d expected 1", vif.frame_idx); else n_pass++;
        @(posedge clk); #1;
        trigger = 1'b1; frame_tick = 1'b1; pos_x = 10'd400; pos_y = 10'd300;
        @(posedge clk); #1;
        trigger = 1'b0; frame_tick = 1'b0;
        m_ticks = 0; m_px = 400; m_py = 300; m_busy = 1; m_mirror = 0;
        n_total++; if (vif.frame_idx !== 3'd0 || busy !== 1'b1) $display("FAIL coincident_trigger: got idx=%0d busy=%b expected idx=0 busy=1", vif.frame_idx, busy); else n_pass++;
        for (int t = 1; t <= 5; t++) begin
            do_tick();
            n_total++;
            if (vif.frame_idx !== 3'(ref_idx()))
                $display("FAIL coincident_hold_cleared: got idx=%0d expected %0d", vif.frame_idx, ref_idx());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_play();
        bit chk, bb, ba; logic [12:0] e;
        do_trigger(200, 100, 1'b0, bb, ba);
        pix_start();
        repeat (3) pix(210, 110, 1'b1, chk, e);
        n_total++; if ({vif.sprite_on, vif.rgb} !== e || vif.sprite_on !== 1'b1) $display("FAIL pre_reset_hit: got on=%b rgb=%h expected on=1 rgb=%h", vif.sprite_on, vif.rgb, e[11:0]); else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_busy = 0; m_px = 0; m_py = 0; m_mirror = 0; m_ticks = 0;
        n_total++; if (busy !== 1'b0) $display("FAIL midplay_reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (vif.sprite_on !== 1'b0 || vif.rgb !== 12'h000) $display("FAIL midplay_reset_pixel: got on=%b rgb=%h expected on=0 rgb=000", vif.sprite_on, vif.rgb); else n_pass++;
        n_total++; if (vif.rom_row !== 6'(110 % 64) || vif.rom_col !== 6'(210 % 64)) $display("FAIL midplay_reset_addr: got row=%0d col=%0d expected row=%0d col=%0d", vif.rom_row, vif.rom_col, 110 % 64, 210 % 64); else n_pass++;
    endtask

`ifdef BLOOD_MIRROR_EN
    task automatic test_mirror();
        bit chk, bb, ba; logic [12:0] e;
        do_trigger(300, 200, 1'b1, bb, ba);
        pix_start();
        pix(302, 205, 1'b1, chk, e);
        #1;
        n_total++; if (vif.rom_col !== 6'd61 || vif.rom_row !== 6'd5) $display("FAIL mirror_addr: got col=%0d row=%0d expected col=61 row=5", vif.rom_col, vif.rom_row); else n_pass++;
        for (int i = 0; i < 400; i++) begin
            pix(290 + $urandom_range(0, 83), 190 + $urandom_range(0, 83), 1'b1, chk, e);
            if (chk) begin
                n_total++;
                if ({vif.sprite_on, vif.rgb} !== e)
                    $display("FAIL mirror_render: got on=%b rgb=%h expected on=%b rgb=%h",
                             vif.sprite_on, vif.rgb, e[12], e[11:0]);
                else n_pass++;
            end
        end
        do_trigger(300, 200, 1'b0, bb, ba);
        vif.pixel_x = 10'd302; vif.pixel_y = 10'd205;
        #1;
        n_total++; if (vif.rom_col !== 6'd2) $display("FAIL unmirror_addr: got col=%0d expected 2", vif.rom_col); else n_pass++;
    endtask
`endif

    initial begin
        vif.pixel_x = '0; vif.pixel_y = '0; vif.video_on = 1'b0;
        test_reset();
        test_idle_scan();
        test_basic_render();
        test_edge_clip();
        test_random_render();
        test_animation();
        test_retrigger();
        test_reset_mid_play();
`ifdef BLOOD_MIRROR_EN
        test_mirror();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/blood_sprite_renderer.md
# blood_sprite_renderer

Read-side driver for the 64×64, 12-bit blood-splatter sprite ROMs. It converts the VGA scan position into ROM `row`/`col` addresses and selects the animation frame index for the external per-frame ROM mux. It absorbs the ROM's one-cycle registered-address latency and emits a registered, transparency-keyed pixel (`sprite_on`, `rgb`) to the fighter display mux. A trigger starts a one-shot animation at a latched screen position.

## Interface
- `NUM_FRAMES`, 8: animation frames, each backed by one ROM; frame index width is `$clog2(NUM_FRAMES)`.
- `HOLD_FRAMES`, 4: video frames each animation frame is displayed; ≥1.
- `TRANSPARENT`, 12'h000: color key treated as see-through.
- `clk` in 1: system/pixel clock.
- `reset` in 1: synchronous, active-high.
- `trigger` in 1: single-cycle pulse that starts or restarts the animation.
- `pos_x` in 10: sprite left edge; latched on `trigger`.
- `pos_y` in 10: sprite top edge; latched on `trigger`.
- `pixel_x` in 10: current scan column.
- `pixel_y` in 10: current scan row.
- `video_on` in 1: active display region.
- `frame_tick` in 1: one-cycle pulse per video frame, at vsync start.
- `rom_row` out 6: ROM row address, combinational.
- `rom_col` out 6: ROM column address, combinational.
- `frame_idx` out clog2(NUM_FRAMES): selects which frame ROM drives `rom_color`.
- `rom_color` in 12: ROM data, valid one clock after the address.
- `sprite_on` out 1: current pixel is an opaque sprite pixel.
- `rgb` out 12: sprite color.
- `busy` out 1: animation playing.

## Operation
- **States:** IDLE, PLAY.
- **IDLE → PLAY** on `trigger`:
  - latch `pos_x` and `pos_y`;
  - clear `frame_idx` and `hold_cnt`.
- **In PLAY, on `frame_tick`:**
  - if `hold_cnt` < HOLD_FRAMES-1: `hold_cnt`++;
  - otherwise clear `hold_cnt`. If `frame_idx` < NUM_FRAMES-1, `frame_idx`++. Else go to IDLE and clear `frame_idx`.
- **Trigger in PLAY:** restart with a new latch, `frame_idx`=0 and `hold_cnt`=0.
- **Trigger and frame_tick in the same cycle:** trigger wins.
- **Frame index updates** occur only on `frame_tick`, so there is no mid-frame tearing.
- **`busy`** = (state==PLAY).
- **Address path (stage 0):**
  - `dx` = {1'b0,`pixel_x`} − {1'b0,`pos_x`}, 11-bit;
  - `dy` is formed the same way from `pixel_y` and `pos_y`;
  - hit0 = `busy` & `video_on` & (`dx`[10:6]==0) & (`dy`[10:6]==0). This rejects negative differences through the wrap to high values. Sprites past the right or bottom edge clip naturally.
  - `rom_row` = `dy`[5:0], `rom_col` = `dx`[5:0], always driven even when there is no hit.
- **Stage 1:** hit1 <= hit0; at this stage `rom_color` corresponds to the stage-0 address.
- **Stage 2 (registered outputs):**
  - `sprite_on` <= hit1 & (`rom_color` != TRANSPARENT);
  - `rgb` <= hit1 ? `rom_color` : 12'h000.

## Timing
- **Reset values:**
  - state IDLE, `busy` 0, `frame_idx` 0, `hold_cnt` 0;
  - latched position 0;
  - hit pipeline 0, `sprite_on` 0, `rgb` 12'h000.
- **`rom_row`/`rom_col`** are combinational from inputs and the latched position; after reset they equal the low bits of `pixel_y`/`pixel_x`.
- **Pixel latency:** `pixel_x`/`pixel_y` → `sprite_on`/`rgb` is 2 clocks. The display mux delays its background path by 2 to match.
- **Trigger latency:** `busy` rises 1 clock after `trigger`. The first hit is possible in the same clock `busy` is high.
- **Animation length:** NUM_FRAMES×HOLD_FRAMES `frame_tick`s from trigger to IDLE. `busy` falls the clock after the final `frame_tick`.
- **Reset mid-PLAY:** immediate return to IDLE. Pipeline registers clear, so `sprite_on`=0 on the next clock.

## Configuration
- **`BLOOD_MIRROR_EN` defined:**
  - adds input `mirror` (1 bit), latched on `trigger` with the position;
  - when the latched value is 1, `rom_col` = 6'd63 − `dx`[5:0] (horizontal flip for a left-facing fighter);
  - hit logic is unchanged.
- **Undefined:** no `mirror` port; `rom_col` = `dx`[5:0].

## Structure
- **Package `blood_pkg`:**
  - SPRITE_DIM=64, SPRITE_AW=6, COLOR_W=12, SCREEN_W=10;
  - default TRANSPARENT;
  - state enum {IDLE, PLAY}.
- **Sub-module `blood_anim_ctrl`:**
  - contains the FSM, `hold_cnt`, `frame_idx` and the trigger latch;
  - outputs `busy`, `frame_idx`, latched position (and latched mirror when enabled).
- **Top level:** the address/hit pipeline, instantiating `blood_anim_ctrl`.

## Test plan
- **Reset and idle scan:** reset, then scan the full 640×480 with no trigger → `sprite_on`=0 and `busy`=0 throughout.
- **Basic render:** trigger at (100,50) with a ROM model returning `{row,col}`-encoded data; scan (100..163, 50..113) → `sprite_on` is high 2 clocks after each address except on TRANSPARENT pixels. `rgb` at (110,60) is the ROM word at row 10, col 10. At (99,50) and (164,50): `sprite_on`=0.
- **Edge clip:** trigger at (620,470) → hits only for x 620..639 and y 470..479. No wrap hits at x=0..43.
- **Animation timing:** NUM_FRAMES=8, HOLD_FRAMES=4. After trigger, `frame_idx` steps 0→7 every 4 `frame_tick`s. `busy` falls after the 32nd tick and `frame_idx` returns to 0.
- **Retrigger:**
  - a `trigger` at (300,200) during frame 5 → `frame_idx`=0 and the new position is used;
  - `trigger` coincident with the frame-advancing `frame_tick` → `frame_idx`=0, not advanced.
- **Reset mid-play, and mirror (with `BLOOD_MIRROR_EN`):**
  - `reset` during PLAY → `busy`=0 and `sprite_on`=0 on the next clock;
  - mirror=1 at `pixel_x`=pos_x+2 → `rom_col`=61.
